scan_doubler: RTL

- Consumes the 15 kHz Spectrum raster produced by the video generator (blank, sync, 24-bit rgb at pixel enable `ce_i`).
- Re-emits every input line twice at double pixel rate, giving a 31 kHz progressive raster for the HDMI/VGA output path.
- Ping-pong line buffer:
  - One bank is written with the current input line.
  - The other bank is read out twice.
- Sits between the video generator and the HDMI encoder.

---
 rtl/scan_doubler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/scan_doubler.sv
`timescale 1ns/1ps
// Line doubler: re-emits each 15 kHz input line twice at 2x pixel rate (31 kHz progressive).
// Latency: output pixel n follows input pixel n by one input line plus 2 ce_o ticks.
// Backpressure: none; free-running pixel enables, a ping-pong bank pair decouples write from read.
//
// Ports: clock/reset_n (async active-low); ce_i/ce_o input/output pixel enables (ce_o = 2x ce_i);
//        blank_i/sync_i/rgb_i input raster; blank_o/sync_o/rgb_o doubled raster; locked = line length stable.
// Option: define SCAN_DOUBLER_SCANLINES_EN to halve the intensity of the second copy of each line.
module scan_doubler #(
  parameter int LINE_MAX = 512,
  parameter int LINE_DEF = 448,
  parameter int HS_START = 188,
  parameter int HS_LEN   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce_i,
  input  logic        ce_o,
  input  logic        blank_i,
  input  logic [1:0]  sync_i,
  input  logic [23:0] rgb_i,
  output logic        blank_o,
  output logic [1:0]  sync_o,
  output logic [23:0] rgb_o,
  output logic        locked
);

  localparam int AW = $clog2(LINE_MAX);
  localparam int LW = AW + 1;  // len can reach LINE_MAX itself
  localparam logic [AW-1:0] X_MAX = AW'(LINE_MAX - 1);

  logic [AW-1:0] wx_q, wx_d;
  logic [AW-1:0] rx_q, rx_d;
  logic [LW-1:0] len_q, len_d;
  logic          wbank_q, wbank_d;
  logic          rep_q, rep_d;
  logic          hs_prev_q, hs_prev_d;
  logic          vs_dly_q, vs_dly_d;
  logic [1:0]    lock_cnt_q, lock_cnt_d;

  logic          hs_rise;
  logic          rd_step;
  logic          hs_win;
  logic [LW-1:0] wx_len;

  // Both banks in one array; the bank select is the address MSB.
  logic [24:0]   mem_q [2*LINE_MAX];
  logic [24:0]   rd_dat_q;
  logic [23:0]   rgb_vis;

  assign hs_rise = ce_i & sync_i[0] & ~hs_prev_q;
  // A realign owns the read pointer on that cycle; the ce_o step is dropped.
  assign rd_step = ce_o & ~hs_rise;
  assign wx_len  = {1'b0, wx_q} + LW'(1);
  assign hs_win  = ({1'b0, rx_q} >= LW'(HS_START)) &&
                   ({1'b0, rx_q} <  LW'(HS_START + HS_LEN));
  assign locked  = (lock_cnt_q == 2'd3);

  always_comb begin
    wx_d       = wx_q;
    rx_d       = rx_q;
    len_d      = len_q;
    wbank_d    = wbank_q;
    rep_d      = rep_q;
    hs_prev_d  = hs_prev_q;
    vs_dly_d   = vs_dly_q;
    lock_cnt_d = lock_cnt_q;

    if (ce_i) begin
      hs_prev_d = sync_i[0];
      if (hs_rise) begin
        wx_d     = '0;
        len_d    = wx_len;
        wbank_d  = ~wbank_q;
        vs_dly_d = sync_i[1];
        // A saturated line never counts as stable, even if len matched.
        if ((wx_len == len_q) && (wx_q != X_MAX)) begin
          lock_cnt_d = (lock_cnt_q == 2'd3) ? 2'd3 : lock_cnt_q + 2'd1;
        end else begin
          lock_cnt_d = '0;
        end
      end else if (wx_q != X_MAX) begin
        wx_d = wx_q + AW'(1);
      end
    end

    if (hs_rise) begin
      rx_d  = '0;
      rep_d = 1'b0;
    end else if (ce_o) begin
      if ({1'b0, rx_q} == len_q - LW'(1)) begin
        rx_d  = '0;
        rep_d = ~rep_q;
      end else begin
        rx_d = rx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wx_q       <= '0;
      rx_q       <= '0;
      len_q      <= LW'(LINE_DEF);
      wbank_q    <= 1'b0;
      rep_q      <= 1'b0;
      hs_prev_q  <= 1'b0;
      vs_dly_q   <= 1'b0;
      lock_cnt_q <= '0;
      blank_o    <= 1'b1;
      sync_o     <= '0;
      rgb_o      <= '0;
    end else begin
      wx_q       <= wx_d;
      rx_q       <= rx_d;
      len_q      <= len_d;
      wbank_q    <= wbank_d;
      rep_q      <= rep_d;
      hs_prev_q  <= hs_prev_d;
      vs_dly_q   <= vs_dly_d;
      lock_cnt_q <= lock_cnt_d;
      if (ce_o) begin
        blank_o <= rd_dat_q[24];
        rgb_o   <= rgb_vis;
        sync_o  <= {vs_dly_q, hs_win};
      end
    end
  end

`ifdef SCAN_DOUBLER_SCANLINES_EN
  logic rd_rep_q;
`endif

  // Line-buffer storage and registered read port: no reset so it maps to block RAM.
  always_ff @(posedge clock) begin
    if (ce_i) begin
      mem_q[{wbank_q, wx_q}] <= {blank_i, rgb_i};
    end
    if (rd_step) begin
      rd_dat_q <= mem_q[{~wbank_q, rx_q}];
`ifdef SCAN_DOUBLER_SCANLINES_EN
      rd_rep_q <= rep_q;
`endif
    end
  end

`ifdef SCAN_DOUBLER_SCANLINES_EN
  // Second copy of each line at half intensity, per 8-bit channel.
  always_comb begin
    rgb_vis = rd_dat_q[24] ? 24'h0 : rd_dat_q[23:0];
    if (rd_rep_q) begin
      rgb_vis = {1'b0, rgb_vis[23:17], 1'b0, rgb_vis[15:9], 1'b0, rgb_vis[7:1]};
    end
  end
`else
  assign rgb_vis = rd_dat_q[24] ? 24'h0 : rd_dat_q[23:0];
`endif

endmodule
